// File: rtl/ex_unit.sv
// ex_unit: RV32I execute stage. It resolves ALU ops, branches and jumps, and
// generates memory addresses. Results go into the EX/MEM register. Shifts run
// one bit per cycle and stall upstream while the shifter is busy.
module ex_unit #(
    parameter int XLEN = 32,
    parameter int OPW  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic [OPW-1:0]  op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic [OPW-1:0]  mem_op_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic            branch_flag_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic            stall_o
);
    localparam logic [OPW-1:0] OP_NOP = 0,  OP_ADD = 1,  OP_SUB = 2,  OP_SLL = 3,
                               OP_SLT = 4,  OP_SLTU = 5, OP_XOR = 6,  OP_SRL = 7,
                               OP_SRA = 8,  OP_OR = 9,   OP_AND = 10, OP_LUI = 11,
                               OP_AUIPC = 12, OP_JAL = 13, OP_JALR = 14,
                               OP_BEQ = 15, OP_BNE = 16, OP_BLT = 17, OP_BGE = 18,
                               OP_BLTU = 19, OP_BGEU = 20,
                               OP_LB = 21, OP_LH = 22, OP_LW = 23, OP_LBU = 24, OP_LHU = 25,
                               OP_SB = 26, OP_SH = 27, OP_SW = 28;

    logic            busy;
    logic [4:0]      cnt;
    logic [XLEN-1:0] acc;

    logic [XLEN-1:0] n_wdata, n_addr, n_mdata, tgt;
    logic [OPW-1:0]  n_mop;
    logic            n_wreg, take, is_shift, start_shift;
    logic [4:0]      shamt;

    assign shamt = reg2_i[4:0];

    // One-bit step of the serial shifter; SRA replicates the sign bit.
    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] a, input logic [OPW-1:0] op);
        case (op)
            OP_SLL:  shift1 = a << 1;
            OP_SRA:  shift1 = {a[XLEN-1], a[XLEN-1:1]};
            default: shift1 = a >> 1;
        endcase
    endfunction

    // Decode the op into next-cycle EX/MEM values and the branch decision.
    always_comb begin
        n_wdata  = '0;
        n_addr   = '0;
        n_mdata  = '0;
        n_mop    = op_i;
        n_wreg   = wreg_i;
        take     = 1'b0;
        tgt      = '0;
        is_shift = 1'b0;
        case (op_i)
            OP_NOP:   n_wreg = 1'b0;
            OP_ADD:   n_wdata = reg1_i + reg2_i;
            OP_SUB:   n_wdata = reg1_i - reg2_i;
            OP_SLT:   n_wdata = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU:  n_wdata = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
            OP_XOR:   n_wdata = reg1_i ^ reg2_i;
            OP_OR:    n_wdata = reg1_i | reg2_i;
            OP_AND:   n_wdata = reg1_i & reg2_i;
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                n_wdata  = reg1_i;  // shamt == 0 result
            end
            OP_LUI:   n_wdata = imm_i;
            OP_AUIPC: n_wdata = pc_i + imm_i;
            OP_JAL: begin
                n_wdata = pc_i + XLEN'(4);
                take    = 1'b1;
                tgt     = pc_i + imm_i;
            end
            OP_JALR: begin
                n_wdata = pc_i + XLEN'(4);
                take    = 1'b1;
                tgt     = (reg1_i + imm_i) & ~XLEN'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                n_wreg = 1'b0;
                tgt    = pc_i + imm_i;
                case (op_i)
                    OP_BEQ:  take = (reg1_i == reg2_i);
                    OP_BNE:  take = (reg1_i != reg2_i);
                    OP_BLT:  take = ($signed(reg1_i) < $signed(reg2_i));
                    OP_BGE:  take = ($signed(reg1_i) >= $signed(reg2_i));
                    OP_BLTU: take = (reg1_i < reg2_i);
                    default: take = (reg1_i >= reg2_i);
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: n_addr = reg1_i + imm_i;
            OP_SB, OP_SH, OP_SW: begin
                n_wreg  = 1'b0;
                n_addr  = reg1_i + imm_i;
                n_mdata = reg2_i;
            end
            default: begin
                n_mop  = '0;
                n_wreg = 1'b0;
            end
        endcase
        start_shift = is_shift && (shamt != 5'd0);
    end

    // Redirect and stall go back upstream in the same cycle. Reset masks both.
    assign branch_flag_o   = !rst && !busy && take;
    assign branch_target_o = branch_flag_o ? tgt : '0;
    assign stall_o         = !rst && (busy ? (cnt > 5'd1) : start_shift);

    // EX/MEM register plus the serial shifter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            mem_op_o   <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else if (busy || start_shift) begin
            // Bubble by default. Only the last shift step writes a real result.
            mem_op_o   <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            if (!busy) begin
                acc  <= reg1_i;
                cnt  <= shamt;
                busy <= 1'b1;
            end else if (cnt > 5'd1) begin
                acc <= shift1(acc, op_i);
                cnt <= cnt - 5'd1;
            end else begin
                busy     <= 1'b0;
                cnt      <= '0;
                wdata_o  <= shift1(acc, op_i);
                wd_o     <= wd_i;
                wreg_o   <= wreg_i;
                mem_op_o <= op_i;
            end
        end else begin
            mem_op_o   <= n_mop;
            wd_o       <= wd_i;
            wreg_o     <= n_wreg;
            wdata_o    <= n_wdata;
            mem_addr_o <= n_addr;
            mem_data_o <= n_mdata;
        end
    end
endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: directed and random checks of ex_unit against an arithmetic reference model.
module tb_ex_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, reg1_i, reg2_i, imm_i;
    logic [6:0]  op_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [6:0]  mem_op_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, mem_addr_o, mem_data_o, branch_target_o;
    logic        branch_flag_o, stall_o;

    int checks = 0;
    int errors = 0;

    ex_unit #(.XLEN(32), .OPW(7)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .op_i(op_i), .reg1_i(reg1_i),
        .reg2_i(reg2_i), .imm_i(imm_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .mem_op_o(mem_op_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .branch_flag_o(branch_flag_o), .branch_target_o(branch_target_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  mop;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, addr, mdata, tgt;
        logic        flag;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // The final result is computed directly from the instruction semantics, not stepped bit by bit.
    function automatic exp_t model(input logic [6:0] op, input logic [31:0] pc, r1, r2, imm,
                                   input logic [4:0] wd, input logic w);
        exp_t e;
        e.mop = op; e.wd = wd; e.wreg = w; e.wdata = 0; e.addr = 0; e.mdata = 0;
        e.tgt = 0; e.flag = 0;
        case (op)
            1:  e.wdata = r1 + r2;
            2:  e.wdata = r1 - r2;
            3:  e.wdata = r1 << r2[4:0];
            4:  e.wdata = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
            5:  e.wdata = (r1 < r2) ? 32'd1 : 32'd0;
            6:  e.wdata = r1 ^ r2;
            7:  e.wdata = r1 >> r2[4:0];
            8:  e.wdata = $unsigned($signed(r1) >>> r2[4:0]);
            9:  e.wdata = r1 | r2;
            10: e.wdata = r1 & r2;
            11: e.wdata = imm;
            12: e.wdata = pc + imm;
            13: begin e.wdata = pc + 4; e.flag = 1; e.tgt = pc + imm; end
            14: begin e.wdata = pc + 4; e.flag = 1; e.tgt = (r1 + imm) & 32'hFFFF_FFFE; end
            15, 16, 17, 18, 19, 20: begin
                e.wreg = 0;
                case (op)
                    15: e.flag = (r1 == r2);
                    16: e.flag = (r1 != r2);
                    17: e.flag = ($signed(r1) < $signed(r2));
                    18: e.flag = ($signed(r1) >= $signed(r2));
                    19: e.flag = (r1 < r2);
                    default: e.flag = (r1 >= r2);
                endcase
                if (e.flag) e.tgt = pc + imm;
            end
            21, 22, 23, 24, 25: e.addr = r1 + imm;
            26, 27, 28: begin e.wreg = 0; e.addr = r1 + imm; e.mdata = r2; end
            0: e.wreg = 0;
            default: begin e.mop = 0; e.wreg = 0; end
        endcase
        return e;
    endfunction

    task automatic chk_regs(input exp_t e);
        chk("mem_op", 32'(mem_op_o), 32'(e.mop));
        chk("wd", 32'(wd_o), 32'(e.wd));
        chk("wreg", 32'(wreg_o), 32'(e.wreg));
        chk("wdata", wdata_o, e.wdata);
        chk("mem_addr", mem_addr_o, e.addr);
        chk("mem_data", mem_data_o, e.mdata);
    endtask

    task automatic chk_zero();
        chk("z_mem_op", 32'(mem_op_o), 32'd0);
        chk("z_wd", 32'(wd_o), 32'd0);
        chk("z_wreg", 32'(wreg_o), 32'd0);
        chk("z_wdata", wdata_o, 32'd0);
        chk("z_mem_addr", mem_addr_o, 32'd0);
        chk("z_mem_data", mem_data_o, 32'd0);
    endtask

    // Call this 1 time unit after a rising edge. It returns 1 time unit after the edge that latches the result.
    task automatic run(input logic [6:0] op, input logic [31:0] pc, r1, r2, imm,
                       input logic [4:0] wd, input logic w);
        exp_t e;
        int   sh;
        pc_i = pc; op_i = op; reg1_i = r1; reg2_i = r2; imm_i = imm; wd_i = wd; wreg_i = w;
        e  = model(op, pc, r1, r2, imm, wd, w);
        sh = (op == 3 || op == 7 || op == 8) ? int'(r2[4:0]) : 0;
        for (int k = 0; k < sh; k++) begin
            #1;
            chk("stall_hi", 32'(stall_o), 32'd1);
            chk("flag_in_stall", 32'(branch_flag_o), 32'd0);
            @(posedge clk); #1;
            chk_zero();
        end
        #1;
        chk("stall_lo", 32'(stall_o), 32'd0);
        chk("branch_flag", 32'(branch_flag_o), 32'(e.flag));
        chk("branch_target", branch_target_o, e.tgt);
        @(posedge clk); #1;
        chk_regs(e);
    endtask

    initial begin
        rst = 1; op_i = 13; pc_i = 32'h40; reg1_i = 0; reg2_i = 0; imm_i = 32'h10;
        wd_i = 1; wreg_i = 1;
        // The reset holds for 2 cycles, with a JAL on the inputs to show that reset masks the flag.
        @(posedge clk); #1;
        chk("rst_flag", 32'(branch_flag_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk_zero();
        rst = 0;
        run(0, 0, 0, 0, 0, 3, 1);
        chk("nop_wreg", 32'(wreg_o), 32'd0);

        // ALU group
        run(1, 0, 32'hFFFF_FFFF, 2, 0, 5, 1);
        chk("add_wrap", wdata_o, 32'd1);
        run(2, 0, 3, 5, 0, 6, 1);
        chk("sub_neg", wdata_o, 32'hFFFF_FFFE);
        run(4, 0, 32'hFFFF_FFFF, 1, 0, 7, 1);
        chk("slt", wdata_o, 32'd1);
        run(5, 0, 32'hFFFF_FFFF, 1, 0, 7, 1);
        chk("sltu", wdata_o, 32'd0);

        // Branches and JALR
        run(16, 32'h100, 1, 2, 32'h20, 0, 0);
        run(15, 32'h100, 1, 2, 32'h20, 0, 0);
        run(14, 32'h300, 32'h201, 0, 2, 1, 1);
        chk("jalr_link", wdata_o, 32'h304);

        // Serial shifts
        run(8, 0, 32'h8000_0000, 3, 0, 9, 1);
        chk("sra_result", wdata_o, 32'hF000_0000);
        run(3, 0, 32'h1234_5678, 0, 0, 10, 1);
        chk("sll_zero", wdata_o, 32'h1234_5678);

        // Store
        run(28, 0, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 0, 1);
        chk("sw_addr", mem_addr_o, 32'h0000_0FFC);

        // SRL by 31, with reset asserted in the 5th cycle of the shift
        pc_i = 0; op_i = 7; reg1_i = 32'hFFFF_FFFF; reg2_i = 31; imm_i = 0; wd_i = 4; wreg_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1; chk("srl_stall", 32'(stall_o), 32'd1);
            @(posedge clk); #1;
        end
        rst = 1;
        #1;
        chk("rst_mid_stall", 32'(stall_o), 32'd0);
        chk("rst_mid_flag", 32'(branch_flag_o), 32'd0);
        @(posedge clk); #1;
        chk_zero();
        rst = 0;
        run(1, 0, 32'd10, 32'd20, 0, 2, 1);
        chk("post_rst_add", wdata_o, 32'd30);

        // Random ops, including undefined codes 29..31, and shifts of any length
        for (int i = 0; i < 80; i++) begin
            run(7'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stop a hung run: report it as a failure and end.
    initial begin
        #400000;
        $display("FAIL timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Execute stage of the RV32I pipeline. It consumes the operands held in the ID/EX register and performs ALU, branch and jump resolution plus memory-address generation.
- Results are registered into the EX/MEM boundary.
- It drives the branch-flush and stall signals back toward the upstream stages.
- Shifts use a 1-bit-per-cycle serial shifter, which stalls upstream while it is busy.

Parameters:
- XLEN, 32, datapath width.
- OPW, 7, internal operation-code width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_i  in  XLEN  PC of the instruction in EX.
- op_i  in  OPW  internal op code (encoding under Behaviour).
- reg1_i  in  XLEN  rs1 value.
- reg2_i  in  XLEN  rs2 value, or the immediate for I-type ALU ops (substituted by ID).
- imm_i  in  XLEN  sign-extended immediate.
- wd_i  in  5  destination register.
- wreg_i  in  1  destination write enable.
- mem_op_o  out  OPW  op forwarded to MEM; registered; reset 0.
- wd_o  out  5  registered; reset 0.
- wreg_o  out  1  registered; reset 0.
- wdata_o  out  XLEN  ALU/link result; registered; reset 0.
- mem_addr_o  out  XLEN  load/store address; registered; reset 0.
- mem_data_o  out  XLEN  store data; registered; reset 0.
- branch_flag_o  out  1  combinational; taken branch or jump; flushes IF/ID and ID/EX; 0 in reset.
- branch_target_o  out  XLEN  combinational redirect PC; 0 when branch_flag_o is 0.
- stall_o  out  1  combinational; holds PC, IF/ID and ID/EX; 0 in reset.

Behaviour:
- Reset is synchronous and active-high; the clock is clk and the reset is rst. On rst all registered outputs go to 0, busy=0, cnt=0.
- Op codes:
  - NOP=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10.
  - LUI=11, AUIPC=12, JAL=13, JALR=14.
  - BEQ=15, BNE=16, BLT=17, BGE=18, BLTU=19, BGEU=20.
  - LB..LHU=21..25, SB=26, SH=27, SW=28.
  - Any other value is treated as NOP: wreg_o=0 and no branch.
- Normal op, one-cycle latency: registered outputs latch at the end of the cycle the op is present.
  - ALU ops: wdata = f(reg1, reg2), with 32-bit wrap.
  - SLT is signed, SLTU is unsigned; both give a 1/0 result.
  - LUI: wdata=imm. AUIPC: wdata=pc+imm.
  - wd_o=wd_i, wreg_o=wreg_i, mem_op_o=op_i.
- Loads/stores: mem_addr = reg1+imm. mem_data = reg2 for stores, 0 otherwise.
- Branches: branch_flag_o=1 in the same cycle when the condition holds; target = pc+imm. wreg_o=0.
- JAL: flag=1, target=pc+imm, wdata=pc+4.
- JALR: flag=1, target=(reg1+imm) with bit0 cleared, wdata=pc+4.
- Shifts (SLL/SRL/SRA), with shamt = reg2[4:0]:
  - shamt=0: one-cycle result = reg1; no stall.
  - Cycle 0 (busy=0, shamt>0): acc<=reg1, cnt<=shamt, busy<=1, stall_o=1. Registered outputs latch a bubble (all 0).
  - Busy cycles with cnt>1: acc shifts one bit (SRA replicates bit 31), cnt decrements, stall_o=1, bubble output.
  - Busy cycle with cnt==1: stall_o=0. wdata_o latches acc shifted once more, with the real wd/wreg/op. busy<=0.
  - Total: stall_o is high for exactly shamt cycles, and the result appears shamt+1 cycles after the op arrives.
- While busy, inputs are held by upstream. The block uses its internal acc and ignores changes to reg1_i.
- Reset mid-shift: rst wins. busy=0, outputs=0, stall_o=0 in that same cycle.
- branch_flag_o and stall_o are never both 1, because branch ops never stall.
- Writes to x0: wd_o=0 is passed through unchanged; the register file ignores it.

Test Plan:
- rst held for 2 cycles → all registered outputs 0, branch_flag_o=0, stall_o=0. Release with op=NOP → wreg_o=0.
- ADD reg1=0xFFFFFFFF, reg2=2, wd=5, wreg=1 → next cycle wdata_o=1, wd_o=5, wreg_o=1. SUB 3-5 → 0xFFFFFFFE. SLT -1<1 → 1. SLTU on the same operands → 0.
- BNE pc=0x100, imm=0x20, reg1=1, reg2=2 → same-cycle branch_flag_o=1, target=0x120. BEQ with the same operands → flag=0, target=0. JALR reg1=0x201, imm=2 → target=0x202, wdata=pc+4.
- SRA reg1=0x80000000, shamt=3 → stall_o=1 for 3 cycles, then 0. Bubble outputs during the stall. wdata_o=0xF0000000 one cycle after stall drops. SLL with shamt=0 → no stall, one-cycle result.
- SW reg1=0x1000, imm=-4, reg2=0xDEADBEEF → mem_addr_o=0xFFC, mem_data_o=0xDEADBEEF, wreg_o=0.
- SRL shamt=31 with rst asserted on cycle 5 → stall_o=0 and outputs 0 in that cycle. The next op after reset completes normally in one cycle.
